div32_seq: RTL

Multi-cycle unsigned 32-bit restoring divider that uses the team's carry-chain arithmetic in reverse: subtraction in place of addition. It computes one quotient bit per clock through a single (W+1)-bit subtractor. It is the arithmetic-unit companion for operations the combinational adders cannot cover, and it sits behind a start/done handshake so the datapath can stall on it.

---
 rtl/div_pkg.sv | 5 +
 rtl/div32_seq_sub.sv | 17 +
 rtl/div32_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential divider
package div_pkg;
  localparam int DIV_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div32_seq_sub.sv
// sub_w: (W+1)-bit ripple subtractor a - b as a + ~b + 1; co=1 means no borrow
module sub_w #(
  parameter int W = 32
) (
  output logic [W:0] s,
  output logic       co,
  input  logic [W:0] a,
  input  logic [W:0] b
);
  logic [W+1:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i <= W; i++) begin : g_bit
    assign s[i]   = a[i] ^ ~b[i] ^ c[i];
    assign c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
  end
  assign co = c[W+1];
endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle unsigned restoring divider, one quotient bit per clock
module div32_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);
  localparam int CW = $clog2(W);
  state_t          state_q, state_d;
  logic [W-1:0]    dd_q, dd_d, dv_q, dv_d, quo_q, quo_d, rem_q, rem_d;
  logic [W:0]      pr_q, pr_d, x, t;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d, dz_q, dz_d, co;
  assign x = {pr_q[W-1:0], dd_q[W-1]};
  sub_w #(.W(W)) u_sub (.s(t), .co(co), .a(x), .b({1'b0, dv_q}));
  // next-state: accept/divide-by-zero in IDLE, one restoring step per RUN cycle
  always_comb begin
    state_d = state_q;
    dd_d    = dd_q;
    dv_d    = dv_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (b != '0) begin
          state_d = RUN;
          dd_d    = a;
          dv_d    = b;
          pr_d    = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = a;
          dz_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        pr_d  = co ? t : x;
        dd_d  = {dd_q[W-2:0], co};
        cnt_d = cnt_q + CW'(1);
        // final step publishes results so they are valid alongside done
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = dd_d;
          rem_d   = pr_d[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, async active-low clear aborts any operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dd_q    <= '0;
      dv_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dd_q    <= dd_d;
      dv_q    <= dv_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign q    = quo_q;
  assign r    = rem_q;
  assign dz   = dz_q;
endmodule
